bus_xfer_sequencer: RTL and testbench

Sequences register-to-register transfers on the shared Bat Amateur data bus. It drives per-register ENABLE/RW/COUNT strobes for a bank of bidirectional registers, so at most one register ever drives the bus. It accepts one request at a time through a valid/ready handshake: move, increment, or move-then-increment-source (PC/MAR fetch style). It sits between the instruction decoder and the register bank.

---
 rtl/bus_xfer_sequencer.sv | 117 +++++++++++
 tb/tb_bus_xfer_sequencer.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_xfer_sequencer.sv
// rtl/bus_xfer_sequencer.sv - register-to-register transfer sequencer for a shared bidirectional data bus
// One request at a time; all register strobes decode from state and latched fields only.
module bus_xfer_sequencer #(
    parameter int NUM_REGS  = 8,
    parameter int SEL_WIDTH = 3
) (
    input  logic                 CLOCK,
    input  logic                 RESET,
    input  logic                 REQ_VALID,
    output logic                 REQ_READY,
    input  logic [1:0]           REQ_OP,
    input  logic [SEL_WIDTH-1:0] REQ_SRC,
    input  logic [SEL_WIDTH-1:0] REQ_DST,
    output logic [NUM_REGS-1:0]  REG_ENABLE,
    output logic [NUM_REGS-1:0]  REG_RW,
    output logic [NUM_REGS-1:0]  REG_COUNT,
    output logic                 BUS_BUSY,
    output logic                 DONE,
    output logic                 ERROR
);

    typedef enum logic [2:0] {
        IDLE,
        TURN,
        XFER,
        INCR,
        FIN,
        ERR
    } state_t;

    localparam logic [1:0] OP_MOVE     = 2'b00;
    localparam logic [1:0] OP_INC      = 2'b01;
    localparam logic [1:0] OP_MOVE_INC = 2'b10;
    localparam logic [1:0] OP_RSVD     = 2'b11;

    state_t                state;
    state_t                state_next;
    logic [1:0]            op;
    logic [SEL_WIDTH-1:0]  src;
    logic [SEL_WIDTH-1:0]  dst;
    logic                  take;
    logic                  src_oob;
    logic                  dst_oob;
    logic                  illegal;
    logic [NUM_REGS-1:0]   src_onehot;
    logic [NUM_REGS-1:0]   dst_onehot;

    assign take    = REQ_VALID && REQ_READY;
    assign src_oob = 32'(REQ_SRC) >= NUM_REGS;
    assign dst_oob = 32'(REQ_DST) >= NUM_REGS;
    // INC never uses the source field, so it is not range- or alias-checked.
    assign illegal = (REQ_OP == OP_RSVD) || dst_oob ||
                     ((REQ_OP != OP_INC) && (src_oob || (REQ_SRC == REQ_DST)));

    assign src_onehot = NUM_REGS'(1) << src;
    assign dst_onehot = NUM_REGS'(1) << dst;

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state <= IDLE;
            op    <= 2'b00;
            src   <= '0;
            dst   <= '0;
        end else begin
            state <= state_next;
            if (take) begin
                op  <= REQ_OP;
                src <= REQ_SRC;
                dst <= REQ_DST;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (take) begin
                    if (illegal)
                        state_next = ERR;
                    else if (REQ_OP == OP_INC)
                        state_next = INCR;
                    else
                        state_next = TURN;
                end
            end
            TURN:    state_next = XFER;
            XFER:    state_next = (op == OP_MOVE_INC) ? INCR : FIN;
            INCR:    state_next = FIN;
            FIN:     state_next = IDLE;
            ERR:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        REG_ENABLE = '0;
        REG_RW     = '1;
        REG_COUNT  = '0;
        DONE       = 1'b0;
        ERROR      = 1'b0;
        BUS_BUSY   = (state != IDLE);
        // Held low while reset is asserted so no request is taken across reset.
        REQ_READY  = (state == IDLE) && !RESET;
        case (state)
            XFER: begin
                REG_ENABLE = src_onehot | dst_onehot;
                REG_RW     = ~dst_onehot;
            end
            INCR:    REG_COUNT = (op == OP_INC) ? dst_onehot : src_onehot;
            FIN:     DONE  = 1'b1;
            ERR:     ERROR = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_bus_xfer_sequencer.sv
// tb/tb_bus_xfer_sequencer.sv - directed self-checking bench for bus_xfer_sequencer
module tb_bus_xfer_sequencer;

    logic        CLOCK = 1'b0;
    logic        RESET;
    logic        REQ_VALID;
    logic        REQ_READY;
    logic [1:0]  REQ_OP;
    logic [2:0]  REQ_SRC;
    logic [2:0]  REQ_DST;
    logic [7:0]  REG_ENABLE;
    logic [7:0]  REG_RW;
    logic [7:0]  REG_COUNT;
    logic        BUS_BUSY;
    logic        DONE;
    logic        ERROR;

    logic        valid6;
    logic        ready6;
    logic [5:0]  en6;
    logic [5:0]  rw6;
    logic [5:0]  cnt6;
    logic        busy6;
    logic        done6;
    logic        error6;

    int          errors = 0;
    int          checks = 0;
    int          done_cnt = 0;
    int          done_ref;

    logic [15:0] bank [8];
    logic [15:0] bus;
    logic        pl_en;
    logic [2:0]  pl_idx;
    logic [15:0] pl_val;

    always #5 CLOCK = ~CLOCK;

    bus_xfer_sequencer #(.NUM_REGS(8), .SEL_WIDTH(3)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY),
        .REQ_OP(REQ_OP), .REQ_SRC(REQ_SRC), .REQ_DST(REQ_DST),
        .REG_ENABLE(REG_ENABLE), .REG_RW(REG_RW), .REG_COUNT(REG_COUNT),
        .BUS_BUSY(BUS_BUSY), .DONE(DONE), .ERROR(ERROR)
    );

    bus_xfer_sequencer #(.NUM_REGS(6), .SEL_WIDTH(3)) dut6 (
        .CLOCK(CLOCK), .RESET(RESET), .REQ_VALID(valid6), .REQ_READY(ready6),
        .REQ_OP(REQ_OP), .REQ_SRC(REQ_SRC), .REQ_DST(REQ_DST),
        .REG_ENABLE(en6), .REG_RW(rw6), .REG_COUNT(cnt6),
        .BUS_BUSY(busy6), .DONE(done6), .ERROR(error6)
    );

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    // Bidirectional register bank: the single driver feeds the bus, loaders capture it.
    always_comb begin
        bus = 16'h0000;
        for (int i = 0; i < 8; i++)
            if (REG_ENABLE[i] && REG_RW[i])
                bus = bus | bank[i];
    end

    always @(posedge CLOCK) begin
        if (RESET) begin
            for (int i = 0; i < 8; i++)
                bank[i] <= 16'h0000;
        end else begin
            if (pl_en)
                bank[pl_idx] <= pl_val;
            for (int i = 0; i < 8; i++) begin
                if (REG_ENABLE[i] && !REG_RW[i])
                    bank[i] <= bus;
                if (REG_COUNT[i])
                    bank[i] <= bank[i] + 16'h0001;
            end
            if (DONE)
                done_cnt <= done_cnt + 1;
        end
    end

    always @(negedge CLOCK) begin
        check_eq("bus_invariant",
                 32'(($countones(REG_ENABLE & REG_RW) <= 1) &&
                     ((~REG_RW & ~REG_ENABLE) == 8'h00) &&
                     ($countones(REG_COUNT) <= 1)), 32'd1);
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic preload(input logic [2:0] idx, input logic [15:0] val);
        pl_en  = 1'b1;
        pl_idx = idx;
        pl_val = val;
        @(negedge CLOCK);
        pl_en  = 1'b0;
    endtask

    task automatic issue(input logic [1:0] op, input logic [2:0] s, input logic [2:0] d);
        REQ_VALID = 1'b1;
        REQ_OP    = op;
        REQ_SRC   = s;
        REQ_DST   = d;
        @(negedge CLOCK);
        REQ_VALID = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check_eq({tag, "_en"}, 32'(REG_ENABLE), 32'h00);
        check_eq({tag, "_rw"}, 32'(REG_RW), 32'hFF);
        check_eq({tag, "_cnt"}, 32'(REG_COUNT), 32'h00);
    endtask

    initial begin
        RESET = 1'b1; REQ_VALID = 1'b1; valid6 = 1'b0;
        REQ_OP = 2'b01; REQ_SRC = 3'd0; REQ_DST = 3'd1;
        pl_en = 1'b0; pl_idx = 3'd0; pl_val = 16'h0000;

        @(negedge CLOCK);
        check_eq("rst_ready_c1", 32'(REQ_READY), 32'd0);
        @(negedge CLOCK);
        check_eq("rst_ready_c2", 32'(REQ_READY), 32'd0);
        RESET = 1'b0; REQ_VALID = 1'b0;
        @(negedge CLOCK);
        check_idle_outputs("post_rst");
        check_eq("post_rst_ready", 32'(REQ_READY), 32'd1);
        check_eq("post_rst_busy", 32'(BUS_BUSY), 32'd0);
        check_eq("post_rst_r1", 32'(bank[1]), 32'h0000);

        // MOVE 2 -> 5
        preload(3'd2, 16'h1234);
        done_ref = done_cnt;
        issue(2'b00, 3'd2, 3'd5);
        check_idle_outputs("mv_turn");
        check_eq("mv_turn_ready", 32'(REQ_READY), 32'd0);
        check_eq("mv_turn_busy", 32'(BUS_BUSY), 32'd1);
        @(negedge CLOCK);
        check_eq("mv_xfer_en", 32'(REG_ENABLE), 32'h24);
        check_eq("mv_xfer_rw", 32'(REG_RW), 32'hDF);
        check_eq("mv_xfer_done", 32'(DONE), 32'd0);
        @(negedge CLOCK);
        check_eq("mv_fin_done", 32'(DONE), 32'd1);
        check_idle_outputs("mv_fin");
        @(negedge CLOCK);
        check_eq("mv_idle_done", 32'(DONE), 32'd0);
        check_eq("mv_idle_ready", 32'(REQ_READY), 32'd1);
        check_eq("mv_r5", 32'(bank[5]), 32'h1234);
        check_eq("mv_r2", 32'(bank[2]), 32'h1234);
        check_eq("mv_done_count", 32'(done_cnt - done_ref), 32'd1);

        // MOVE_INC 0 -> 3 with source wrap
        preload(3'd0, 16'hFFFF);
        issue(2'b10, 3'd0, 3'd3);
        check_idle_outputs("mi_turn");
        @(negedge CLOCK);
        check_eq("mi_xfer_en", 32'(REG_ENABLE), 32'h09);
        check_eq("mi_xfer_rw", 32'(REG_RW), 32'hF7);
        @(negedge CLOCK);
        check_eq("mi_incr_cnt", 32'(REG_COUNT), 32'h01);
        check_eq("mi_incr_en", 32'(REG_ENABLE), 32'h00);
        check_eq("mi_incr_done", 32'(DONE), 32'd0);
        @(negedge CLOCK);
        check_eq("mi_fin_done", 32'(DONE), 32'd1);
        @(negedge CLOCK);
        check_eq("mi_r3", 32'(bank[3]), 32'hFFFF);
        check_eq("mi_r0", 32'(bank[0]), 32'h0000);

        // INC 7
        issue(2'b01, 3'd0, 3'd7);
        check_eq("inc_cnt", 32'(REG_COUNT), 32'h80);
        check_eq("inc_en", 32'(REG_ENABLE), 32'h00);
        check_eq("inc_rw", 32'(REG_RW), 32'hFF);
        @(negedge CLOCK);
        check_eq("inc_fin_done", 32'(DONE), 32'd1);
        check_eq("inc_fin_cnt", 32'(REG_COUNT), 32'h00);
        @(negedge CLOCK);
        check_eq("inc_r7", 32'(bank[7]), 32'h0001);

        // Illegal requests
        done_ref = done_cnt;
        issue(2'b11, 3'd1, 3'd2);
        check_eq("ill_op_err", 32'(ERROR), 32'd1);
        check_eq("ill_op_done", 32'(DONE), 32'd0);
        check_idle_outputs("ill_op");
        @(negedge CLOCK);
        check_eq("ill_op_err_pulse", 32'(ERROR), 32'd0);
        check_eq("ill_op_ready", 32'(REQ_READY), 32'd1);
        issue(2'b00, 3'd4, 3'd4);
        check_eq("ill_same_err", 32'(ERROR), 32'd1);
        check_idle_outputs("ill_same");
        @(negedge CLOCK);
        check_eq("ill_same_err_pulse", 32'(ERROR), 32'd0);
        check_eq("ill_done_count", 32'(done_cnt - done_ref), 32'd0);

        valid6 = 1'b1; REQ_OP = 2'b01; REQ_SRC = 3'd0; REQ_DST = 3'd6;
        @(negedge CLOCK);
        valid6 = 1'b0;
        check_eq("ill_oob_err", 32'(error6), 32'd1);
        check_eq("ill_oob_cnt", 32'(cnt6), 32'h00);
        check_eq("ill_oob_done", 32'(done6), 32'd0);
        @(negedge CLOCK);
        check_eq("ill_oob_err_pulse", 32'(error6), 32'd0);
        check_eq("ill_oob_ready", 32'(ready6), 32'd1);

        // Reset during XFER of MOVE 1 -> 2
        done_ref = done_cnt;
        issue(2'b00, 3'd1, 3'd2);
        @(negedge CLOCK);
        check_eq("rx_xfer_en", 32'(REG_ENABLE), 32'h06);
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        check_idle_outputs("rx_after");
        check_eq("rx_after_done", 32'(DONE), 32'd0);
        check_eq("rx_after_busy", 32'(BUS_BUSY), 32'd0);
        @(negedge CLOCK);
        check_eq("rx_idle_done", 32'(DONE), 32'd0);
        check_eq("rx_idle_ready", 32'(REQ_READY), 32'd1);
        check_eq("rx_done_count", 32'(done_cnt - done_ref), 32'd0);

        // Back-to-back INC 1, VALID held through the busy cycles
        done_ref = done_cnt;
        REQ_VALID = 1'b1; REQ_OP = 2'b01; REQ_SRC = 3'd0; REQ_DST = 3'd1;
        @(negedge CLOCK);
        check_eq("b2b_incr1_cnt", 32'(REG_COUNT), 32'h02);
        @(negedge CLOCK);
        check_eq("b2b_fin1_done", 32'(DONE), 32'd1);
        @(negedge CLOCK);
        check_eq("b2b_idle_ready", 32'(REQ_READY), 32'd1);
        @(negedge CLOCK);
        REQ_VALID = 1'b0;
        check_eq("b2b_incr2_cnt", 32'(REG_COUNT), 32'h02);
        @(negedge CLOCK);
        check_eq("b2b_fin2_done", 32'(DONE), 32'd1);
        @(negedge CLOCK);
        check_eq("b2b_r1", 32'(bank[1]), 32'h0002);
        check_eq("b2b_done_count", 32'(done_cnt - done_ref), 32'd2);
        check_eq("b2b_final_ready", 32'(REQ_READY), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
